ti_unmask_out: RTL

Output stage of the 2-share TI AES datapath. It collects the final-round state as column-serial share pairs, keeping the two shares in separate registers. After all columns arrive, it recombines them (share0 XOR share1) in a single registered step and presents the 128-bit ciphertext with a valid/acknowledge handshake to the host interface. It is the unmasking counterpart of the initial masking performed at data input, and it zeroizes share storage after use.

---
 rtl/ti_unmask_out.sv | 119 +++++++++++
 1 files changed

// File: rtl/ti_unmask_out.sv
// Output stage of the 2-share datapath: collects column share pairs, unmasks them in one registered XOR, holds the block for the host.
// Latency: last beat accepted -> Dvld high two cycles later; minimum block period NCOL+2 cycles.
// Backpressure: in_ready drops from UNMASK until Dack in HOLD; abort flushes everything.
module ti_unmask_out #(
    parameter int W    = 32,
    parameter int NCOL = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_sh0,
    input  logic [W-1:0]      in_sh1,
    output logic [W*NCOL-1:0] Dout,
    output logic              Dvld,
    input  logic              Dack,
    output logic              busy
);

    localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCOL - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        UNMASK  = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]            cnt;
    logic [CW-1:0]            slot;
    logic [NCOL-1:0][W-1:0]   sh0_reg;
    logic [NCOL-1:0][W-1:0]   sh1_reg;
    logic                     beat_acc;

    // Column 0 lands in the top slot so the packed XOR already has it at the MSBs.
    assign slot     = CNT_LAST - cnt;
    assign beat_acc = in_valid && in_ready && !abort;
    assign busy     = (cnt != '0) || (state != COLLECT);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == CNT_LAST)) begin
                    state_nxt = UNMASK;
                end
            end
            UNMASK: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (Dack) begin
                    state_nxt = COLLECT;
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
        if (abort) begin
            state_nxt = COLLECT;
        end
    end

    // Shares stay in separate registers; the single recombination is the UNMASK update.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt     <= '0;
            sh0_reg <= '0;
            sh1_reg <= '0;
            Dout    <= '0;
            Dvld    <= 1'b0;
        end else if (abort) begin
            cnt     <= '0;
            sh0_reg <= '0;
            sh1_reg <= '0;
            Dout    <= '0;
            Dvld    <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (beat_acc) begin
                        sh0_reg[slot] <= in_sh0;
                        sh1_reg[slot] <= in_sh1;
                        cnt           <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                    end
                end
                UNMASK: begin
                    Dout    <= sh0_reg ^ sh1_reg;
                    sh0_reg <= '0;
                    sh1_reg <= '0;
                    Dvld    <= 1'b1;
                end
                HOLD: begin
                    if (Dack) begin
                        Dvld <= 1'b0;
                    end
                end
                default: begin
                    Dvld <= 1'b0;
                end
            endcase
        end
    end

endmodule
